// File: rtl/out_capture_fifo.sv
// Captures each change of the processor result bus into a show-ahead FIFO, with drop accounting.
// Latency: a value sampled on edge N is presented on m_data/m_valid right after edge N.
// Backpressure: valid/ready drain; when full without a concurrent pop, new samples are dropped and counted.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_vld,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop_rdy,
    output logic              pop_vld,
    output logic [DATA_W-1:0] pop_dat,
    output logic [ADDR_W:0]   cnt,
    output logic              full
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic              pop_en;

    assign pop_vld = (cnt != '0);
    assign full    = (cnt == DEPTH_C);
    assign pop_en  = pop_vld && pop_rdy;
    // Storage is never cleared, so the head is masked while empty.
    assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst && push_vld)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_vld, pop_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module out_capture_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cpu_out,
    input  logic              cap_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              first_seen
);
    logic [DATA_W-1:0] last_val;
    logic              sample;
    logic              pop;
    logic              push;
    logic              drop;

    assign sample = cap_en && (!first_seen || (cpu_out != last_val));
    assign pop    = m_valid && m_ready;
    // A concurrent pop frees the slot, so a full FIFO can still accept.
    assign push   = sample && (!full || pop);
    assign drop   = sample && full && !pop;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push),
        .push_dat (cpu_out),
        .pop_rdy  (m_ready),
        .pop_vld  (m_valid),
        .pop_dat  (m_data),
        .cnt      (count),
        .full     (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_val   <= '0;
            first_seen <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            // last_val tracks every sample, dropped or not, so a held value drops only once.
            if (sample) begin
                last_val   <= cpu_out;
                first_seen <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/out_capture_fifo.md
Name: out_capture_fifo

Overview:
- Sits downstream of the Processor and consumes its 32-bit `out` result bus.
- Each time the value on the bus changes, the block captures it into a DEPTH-entry FIFO.
- A bench or debug port drains the FIFO through a valid/ready interface.
- Provides a cycle-accurate trace of the program's result stream, plus overflow accounting.

Parameters:
- DATA_W, 32: width of the captured processor output.
- DEPTH, 16: number of FIFO entries; must be a power of two.
- ADDR_W, 4: log2(DEPTH); pointer width.
- CNT_W, 16: width of the dropped-sample counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cpu_out  input  DATA_W  processor result bus (Processor `out`).
- cap_en  input  1  capture enable; when low, no samples are taken.
- m_data  output  DATA_W  FIFO head entry.
- m_valid  output  1  head entry is valid.
- m_ready  input  1  consumer accepts the head this cycle.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag; at least one sample was dropped.
- drop_cnt  output  CNT_W  number of dropped samples; saturating.
- first_seen  output  1  at least one sample has been captured since reset.

Behaviour:
- Reset:
  - Takes effect only on a clk edge with rst=1; it is synchronous.
  - Clears rd_ptr, wr_ptr, count, overflow, drop_cnt, first_seen and last_val.
  - After the edge: m_valid=0, full=0, count=0, overflow=0, drop_cnt=0, first_seen=0, m_data=0.
  - FIFO storage is not cleared; m_data is forced to 0 whenever count==0.
  - Reset asserted mid-operation discards all queued entries on that edge. A pop presented in the same cycle is ignored.
- Change detect (combinational):
  - sample = cap_en && (!first_seen || cpu_out != last_val).
- On an edge with sample=1:
  - last_val <= cpu_out.
  - first_seen <= 1.
  - A push is requested.
  - last_val is updated even if the push is dropped, so a held value never generates repeated drops.
- Pop:
  - pop = m_valid && m_ready.
  - On pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
  - m_ready while m_valid=0 has no effect.
- Push acceptance:
  - push = sample && (count < DEPTH || pop).
  - A simultaneous pop frees the slot, so a push into a full FIFO with a concurrent pop is accepted.
  - On push: mem[wr_ptr] <= cpu_out; wr_ptr <= wr_ptr+1, wrapping.
- Drop:
  - Occurs when sample && count == DEPTH && !pop.
  - On drop: overflow <= 1 (stays set until reset); drop_cnt <= drop_cnt+1, saturating at all-ones.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - count never exceeds DEPTH and never underflows.
- Outputs:
  - m_valid = (count != 0).
  - m_data = mem[rd_ptr] (show-ahead head).
  - full = (count == DEPTH).
  - All of the above derive from registered state; no combinational path from cpu_out or m_ready to any output.
- Latency:
  - A value sampled on edge N appears on m_data with m_valid=1 after edge N, when the FIFO was empty.
  - The empty-to-valid delay is 1 cycle.
- Ordering: strict FIFO; entries leave in capture order.
- Holding m_ready=1 continuously drains one entry per cycle.
- cap_en low:
  - No sampling occurs and last_val is frozen.
  - Draining continues normally.
  - When cap_en returns high, a value differing from last_val is captured immediately.

Test Plan:
- Reset then first sample:
  - Stimulus: rst=1 for 2 cycles; release with cpu_out=0, cap_en=1, m_ready=0.
  - Response: one cycle later m_valid=1, m_data=0, count=1, first_seen=1.
  - Holding 0 afterwards leaves count=1.
- Change stream:
  - Stimulus: drive cpu_out 5, 5, 9, 9, 9, 3 on consecutive cycles; then m_ready=1.
  - Response: FIFO holds exactly 5, 9, 3; the drain yields 5, 9, 3 in order, one per cycle; count ends at 0; m_valid=0 and m_data=0 after the last pop.
- Fill and overflow:
  - Stimulus: m_ready=0; drive 20 distinct values 1..20.
  - Response: full=1 after the 16th value; overflow=1; drop_cnt=4; drain yields 1..16.
- Full with simultaneous pop and push:
  - Stimulus: FIFO full with 1..16; one cycle with m_ready=1 and new cpu_out=99.
  - Response: count stays 16, drop_cnt unchanged; drain order is 2..16 then 99.
- Pointer wrap:
  - Stimulus: m_ready=1; drive 40 distinct values.
  - Response: all 40 are received in order with no drops; overflow=0.
- Reset mid-operation:
  - Stimulus: 7 entries queued and overflow=1; pulse rst for one cycle while m_ready=1.
  - Response: next cycle count=0, m_valid=0, overflow=0, drop_cnt=0, first_seen=0.
  - The next cpu_out value is captured as a first sample, even if it is unchanged.
